// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor: the controller state
// encoding and the default operand width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_sub_pkg

// File: rtl/full_adder.sv
// full_adder
// One-bit full adder used as the serial datapath of serial_sub16.
// Ports:
//   x, y, z : input  addend bits and carry-in
//   s       : output sum bit
//   c       : output carry-out
module full_adder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule : full_adder

// File: rtl/serial_sub16.sv
// serial_sub16
// Bit-serial subtractor computing D = A - B (mod 2^WIDTH) one bit per clock,
// LSB first, as A + ~B + 1 through a single full adder.
//
// Ports:
//   Clk       : input  clock, all state changes on the rising edge
//   Reset     : input  synchronous active-high reset, priority over Start
//   Start     : input  level request; accepted only in IDLE
//   A, B      : input  minuend / subtrahend, sampled when Start is accepted
//   D         : output registered difference, updated only on DONE entry
//   Bout      : output registered borrow-out (unsigned A < B)
//   Busy      : output high while in SHIFT
//   Done      : output high while in DONE
//   Ovf       : output signed overflow flag (only with SERIAL_SUB_OVF_EN)
//   dbg_state : output current controller state (IDLE=0, SHIFT=1, DONE=2)
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the Ovf output and its logic.
//
// Handshake: a new operation starts on an edge where the FSM is in IDLE and
// Start=1. Done then stays high for as long as Start is held; the FSM goes
// back to IDLE on the first edge with Start=0, so each Start assertion yields
// exactly one subtraction.
//
// Timing: Start accepted at edge T, the WIDTH serial steps occur on edges
// T+1..T+WIDTH, and edge T+WIDTH+1 moves to DONE while loading D/Bout.
module serial_sub16
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             Busy,
    output logic             Done,
`ifdef SERIAL_SUB_OVF_EN
    output logic             Ovf,
`endif
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept aside because the operand registers shift
    // them away during the serial pass.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic fa_s;
    logic fa_c;

    // Subtraction as A + ~B with the carry register seeded to 1.
    full_adder u_fa (
        .x (a_q[0]),
        .y (~b_q[0]),
        .z (carry_q),
        .s (fa_s),
        .c (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    r_d     = '0;
                    carry_d = 1'b1;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(WIDTH)) begin
                    // All bits processed: publish result; a final carry of 0
                    // means the subtraction borrowed.
                    d_d     = r_q;
                    bout_d  = ~carry_q;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (r_q[WIDTH-1] != a_msb_q);
`endif
                    state_d = DONE;
                end else begin
                    // Sum bits enter at the MSB so the first (LSB) result bit
                    // ends up at bit 0 after WIDTH shifts.
                    r_d     = {fa_s, r_q[WIDTH-1:1]};
                    carry_d = fa_c;
                    a_d     = {1'b0, a_q[WIDTH-1:1]};
                    b_d     = {1'b0, b_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (!Start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign D         = d_q;
    assign Bout      = bout_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
`ifdef SERIAL_SUB_OVF_EN
    assign Ovf       = ovf_q;
`endif
    assign dbg_state = state_q;

endmodule : serial_sub16

// File: tb/tb_serial_sub16.sv
// tb_serial_sub16
// Directed-vector bench for serial_sub16 (WIDTH=16). Expected values are
// hand-computed constants. Ovf is checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub16;

    localparam int W = 16;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] D;
    logic         Bout;
    logic         Busy;
    logic         Done;
`ifdef SERIAL_SUB_OVF_EN
    logic         Ovf;
`endif
    logic [1:0]   dbg_state;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] held_d;

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    serial_sub16 #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .A         (A),
        .B         (B),
        .D         (D),
        .Bout      (Bout),
        .Busy      (Busy),
        .Done      (Done),
`ifdef SERIAL_SUB_OVF_EN
        .Ovf       (Ovf),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One complete operation; Start is a one-cycle pulse. With scramble set,
    // A and B are overwritten with random values during SHIFT.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_d, input logic exp_bout,
                          input logic exp_ovf, input logic scramble);
        int           lat;
        logic [W-1:0] e;
        exp_q.push_back(exp_d);
        @(negedge Clk);
        A = a;
        B = b;
        Start = 1'b1;
        @(posedge Clk);                 // edge T: accepted
        @(negedge Clk);
        Start = 1'b0;
        check("busy_after_accept", 32'(Busy), 32'(1));
        check("d_held_in_shift", 32'(D), 32'(held_d));
        lat = 0;
        while (!Done && lat < 40) begin
            if (scramble) begin
                A = W'($urandom);
                B = W'($urandom);
            end
            @(posedge Clk);
            lat++;
            @(negedge Clk);
        end
        check("done_latency", 32'(lat), 32'(17));
        e = exp_q.pop_front();
        check("d_result", 32'(D), 32'(e));
        check("bout", 32'(Bout), 32'(exp_bout));
        check("busy_in_done", 32'(Busy), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(Ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("unreachable");
`endif
        held_d = e;
        @(posedge Clk);
        @(negedge Clk);
        check("back_to_idle", 32'(dbg_state), 32'(0));
        check("done_cleared", 32'(Done), 32'(0));
        check("d_held_in_idle", 32'(D), 32'(e));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int busy_cnt;
        int done_cnt;
        int first_done;
        int done_seen;

        Reset = 1'b1;
        Start = 1'b1;
        A     = 16'hAAAA;
        B     = 16'h5555;
        held_d = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_d", 32'(D), 32'(0));
        check("rst_bout", 32'(Bout), 32'(0));
        check("rst_busy", 32'(Busy), 32'(0));
        check("rst_done", 32'(Done), 32'(0));
        check("rst_state", 32'(dbg_state), 32'(0));
        Reset = 1'b0;
        Start = 1'b0;

        //     A         B         D         Bout  Ovf  scramble
        run_op(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op(16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_op(16'h4000, 16'hC000, 16'h8000, 1'b1, 1'b1, 1'b1);
        run_op(16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0);

        // Abort mid-SHIFT: Reset on the 7th SHIFT edge.
        @(negedge Clk);
        A = 16'hFFFF;
        B = 16'h0001;
        Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("abort_state", 32'(dbg_state), 32'(0));
        check("abort_d", 32'(D), 32'(0));
        check("abort_bout", 32'(Bout), 32'(0));
        check("abort_busy", 32'(Busy), 32'(0));
        check("abort_done", 32'(Done), 32'(0));
        Reset = 1'b0;
        held_d = '0;
        done_seen = 0;
        repeat (20) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Done || Busy) done_seen++;
        end
        check("abort_no_resume", 32'(done_seen), 32'(0));

        // Start held for 40 cycles: exactly one operation, DONE held.
        @(negedge Clk);
        A = 16'h0010;
        B = 16'h0001;
        Start = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        first_done = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Busy) busy_cnt++;
            if (Done) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
            end
        end
        check("hold_busy_cycles", 32'(busy_cnt), 32'(17));
        check("hold_first_done", 32'(first_done), 32'(17));
        check("hold_done_cycles", 32'(done_cnt), 32'(23));
        check("hold_d", 32'(D), 32'(16'h000F));
        Start = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("hold_release_state", 32'(dbg_state), 32'(0));
        check("hold_release_done", 32'(Done), 32'(0));
        held_d = 16'h000F;

        // New Start after release is accepted.
        run_op(16'h0007, 16'h0009, 16'hFFFE, 1'b1, 1'b0, 1'b0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends with a summary.
    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL timeout: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_sub16

// File: doc/serial_sub16.md
SERIAL_SUB16 -- requirements
Module: serial_sub16

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The module SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port Start, input, 1 bit: level request to begin a subtraction.
REQ-005 The module SHALL have port A, input, WIDTH bits: minuend, sampled only when an operation is accepted.
REQ-006 The module SHALL have port B, input, WIDTH bits: subtrahend, sampled only when an operation is accepted.
REQ-007 The module SHALL have port D, output, WIDTH bits: registered difference A-B mod 2^WIDTH.
REQ-008 The module SHALL have port Bout, output, 1 bit: registered borrow-out, 1 when unsigned A < B.
REQ-009 The module SHALL have port Busy, output, 1 bit: high while in SHIFT.
REQ-010 The module SHALL have port Done, output, 1 bit: high while in DONE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with Start=1 at edge T, the block SHALL capture A and B into internal shift registers, set the carry register to 1, clear the bit counter and enter SHIFT.
REQ-013 Each SHIFT cycle SHALL add operand-A LSB, inverted operand-B LSB and the carry register through one full adder.
- The sum bit SHALL shift into the MSB of the result shift register.
- The carry-out SHALL update the carry register.
- Both operand registers SHALL shift right by one.
- The counter SHALL increment.
REQ-014 SHIFT SHALL last exactly WIDTH cycles (edges T+1..T+WIDTH), and the FSM SHALL then enter DONE.
REQ-015 On the DONE-entry edge, D SHALL load the result register and Bout SHALL load the inverted final carry; Done first reads high after edge T+WIDTH+1.
REQ-016 D and Bout SHALL hold their values outside the DONE-entry edge, including through IDLE and the next SHIFT.
REQ-017 Start SHALL be ignored during SHIFT.
REQ-018 DONE SHALL persist while Start=1, and the FSM SHALL return to IDLE on the first edge with Start=0 (one subtraction per Start assertion).
REQ-019 The arithmetic SHALL be modulo 2^WIDTH; equal operands SHALL give D=0 and Bout=0.

Reset
REQ-020 An edge with Reset=1 SHALL force IDLE, D=0, Bout=0, Busy=0 and Done=0, clear the counter, carry and shift registers, and take priority over Start.
REQ-021 Reset asserted mid-SHIFT SHALL abort the operation with no partial result visible on D.

Configuration
REQ-022 With macro SERIAL_SUB_OVF_EN defined, the module SHALL add output port Ovf, 1 bit, reset 0, loaded with D on the DONE-entry edge as two's-complement overflow: (A[MSB]!=B[MSB]) && (result[MSB]!=A[MSB]).
REQ-023 Without SERIAL_SUB_OVF_EN, port Ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-024 Package serial_sub_pkg SHALL hold the state enum type (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-025 The block SHALL instantiate exactly one existing full_adder sub-module (ports x, y, z, s, c) for the bit-serial datapath.
REQ-026 The counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification
REQ-027 The bench SHALL apply A=0x0005, B=0x0003, Start pulse -> D=0x0002, Bout=0, Done high 17 cycles after Start sampled.
REQ-028 The bench SHALL apply A=0x0003, B=0x0005 -> D=0xFFFE, Bout=1.
REQ-029 The bench SHALL apply A=0x8000, B=0x0001 -> D=0x7FFF, Bout=0, Ovf=1 when enabled; and A=0x1234, B=0x1234 -> D=0x0000, Bout=0, Ovf=0.
REQ-030 The bench SHALL run A=0xFFFF, B=0x0001 and then Reset on the 7th SHIFT cycle -> IDLE next edge, D=0, Bout=0, Busy=0.
REQ-031 The bench SHALL hold Start=1 for 40 cycles -> a single operation, DONE held, no restart until Start=0, and a new Start after that accepted.
REQ-032 The bench SHALL change A and B mid-SHIFT -> result unaffected, equal to the difference of the captured operands.
